hazard_unit: RTL and testbench

Pipeline hazard controller for the five-stage RV32 core and the consumer side of the pipelined control signals. It takes register indices and the stage control bits (`reg_write_m`, `reg_write_w`, `result_src_e`, `pc_src_e`) and returns:
- forwarding selects;
- stall and flush controls, including the `flush_e` consumed by the control unit's D/E register.

It also sequences multi-cycle M-extension operations in Execute through a start/done handshake with the multiply-divide unit. It keeps a stall-cycle performance counter and a timeout watchdog.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/forward_select.sv | 22 ++
 rtl/hazard_unit.sv | 135 +++++++++++++
 tb/tb_hazard_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    IDLE     = 1'b0,
    MDU_WAIT = 1'b1
  } hz_state_e;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/forward_select.sv
// Operand bypass select for one Execute source register; Memory beats Writeback.
module forward_select
  import hazard_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output fwd_sel_e   sel
);

  // NOTE: default assignment first so no path through this block infers a latch.
  always_comb begin
    sel = FWD_RF;
    if (rs_e != 5'd0 && reg_write_m && rs_e == rd_m)
      sel = FWD_MEM;
    else if (rs_e != 5'd0 && reg_write_w && rs_e == rd_w)
      sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_unit.sv
// Five-stage RV32 hazard controller: forwarding, load-use and branch handling,
// MDU start/done sequencing with watchdog, and a saturating stall-cycle counter.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       rs1_d_i,
  input  logic [4:0]       rs2_d_i,
  input  logic [4:0]       rs1_e_i,
  input  logic [4:0]       rs2_e_i,
  input  logic [4:0]       rd_e_i,
  input  logic [4:0]       rd_m_i,
  input  logic [4:0]       rd_w_i,
  input  logic             reg_write_m_i,
  input  logic             reg_write_w_i,
  input  logic [1:0]       result_src_e_i,
  input  logic             pc_src_e_i,
  input  logic             mdu_op_e_i,
  input  logic             mdu_done_i,
  output logic [1:0]       forward_a_e_o,
  output logic [1:0]       forward_b_e_o,
  output logic             stall_f_o,
  output logic             stall_d_o,
  output logic             stall_e_o,
  output logic             flush_d_o,
  output logic             flush_e_o,
  output logic             flush_m_o,
  output logic             mdu_go_o,
  output logic             mdu_busy_o,
  output logic             mdu_timeout_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  localparam int WD_W = $clog2(MDU_TIMEOUT + 1);

  hz_state_e       state;
  logic [WD_W-1:0] wd_cnt;
  logic            lw_stall;
  logic            mdu_stall;
  logic            wd_expire;
  fwd_sel_e        fwd_a;
  fwd_sel_e        fwd_b;

  forward_select u_fwd_a (
    .rs_e        (rs1_e_i),
    .rd_m        (rd_m_i),
    .rd_w        (rd_w_i),
    .reg_write_m (reg_write_m_i),
    .reg_write_w (reg_write_w_i),
    .sel         (fwd_a)
  );

  forward_select u_fwd_b (
    .rs_e        (rs2_e_i),
    .rd_m        (rd_m_i),
    .rd_w        (rd_w_i),
    .reg_write_m (reg_write_m_i),
    .reg_write_w (reg_write_w_i),
    .sel         (fwd_b)
  );

  assign forward_a_e_o = fwd_a;
  assign forward_b_e_o = fwd_b;

  assign lw_stall = (result_src_e_i == RESULT_SRC_LOAD) && (rd_e_i != 5'd0) &&
                    ((rs1_d_i == rd_e_i) || (rs2_d_i == rd_e_i));

  // The last permitted wait cycle releases the pipeline, mirroring a done pulse.
  assign wd_expire = (state == MDU_WAIT) && !mdu_done_i &&
                     (wd_cnt == WD_W'(MDU_TIMEOUT - 1));

  // Start is suppressed under reset so a held MDU op cannot pulse go during reset.
  always_comb begin
    mdu_stall = 1'b0;
    mdu_go_o  = 1'b0;
    unique case (state)
      IDLE: begin
        if (mdu_op_e_i && !rst_i) begin
          mdu_go_o  = 1'b1;
          mdu_stall = 1'b1;
        end
      end
      MDU_WAIT: mdu_stall = !mdu_done_i && !wd_expire;
      default: ;
    endcase
  end

  assign stall_f_o  = lw_stall | mdu_stall;
  assign stall_d_o  = lw_stall | mdu_stall;
  assign stall_e_o  = mdu_stall;
  assign flush_d_o  = pc_src_e_i & ~mdu_stall;
  assign flush_e_o  = (lw_stall | pc_src_e_i) & ~mdu_stall;
  assign flush_m_o  = mdu_stall;
  assign mdu_busy_o = (state == MDU_WAIT);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      wd_cnt         <= '0;
      mdu_timeout_o  <= 1'b0;
      stall_cycles_o <= '0;
    end else begin
      if (stall_f_o && stall_cycles_o != '1)
        stall_cycles_o <= stall_cycles_o + CNT_W'(1);

      unique case (state)
        IDLE: begin
          if (mdu_op_e_i) begin
            state  <= MDU_WAIT;
            wd_cnt <= '0;
          end
        end
        MDU_WAIT: begin
          if (mdu_done_i) begin
            state  <= IDLE;
            wd_cnt <= '0;
          end else if (wd_expire) begin
            state         <= IDLE;
            wd_cnt        <= '0;
            mdu_timeout_o <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: vector table for forwarding/load-use/branch,
// hand-written sequences for the MDU handshake, watchdog, saturation and reset.
module tb_hazard_unit;

  logic       clk;
  logic       rst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       rwm, rww, pcs, mdu_op, mdu_done;
  logic [1:0] rsrc;

  logic [1:0]  fa, fb;
  logic        stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;
  logic        go, busy, tmo;
  logic [31:0] cnt;

  logic [1:0]  s_fa, s_fb;
  logic        s_stall_f, s_stall_d, s_stall_e, s_flush_d, s_flush_e, s_flush_m;
  logic        s_go, s_busy, s_tmo;
  logic [2:0]  s_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_cnt = 0;
  int go_seen;

  hazard_unit #(.MDU_TIMEOUT(8), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .rs1_d_i(rs1_d), .rs2_d_i(rs2_d), .rs1_e_i(rs1_e), .rs2_e_i(rs2_e), .rd_e_i(rd_e),
    .rd_m_i(rd_m), .rd_w_i(rd_w), .reg_write_m_i(rwm), .reg_write_w_i(rww),
    .result_src_e_i(rsrc), .pc_src_e_i(pcs), .mdu_op_e_i(mdu_op), .mdu_done_i(mdu_done),
    .forward_a_e_o(fa), .forward_b_e_o(fb),
    .stall_f_o(stall_f), .stall_d_o(stall_d), .stall_e_o(stall_e),
    .flush_d_o(flush_d), .flush_e_o(flush_e), .flush_m_o(flush_m),
    .mdu_go_o(go), .mdu_busy_o(busy), .mdu_timeout_o(tmo), .stall_cycles_o(cnt)
  );

  // Narrow-counter instance sharing all stimulus, used for the saturation check.
  hazard_unit #(.MDU_TIMEOUT(8), .CNT_W(3)) dut_sat (
    .clk_i(clk), .rst_i(rst),
    .rs1_d_i(rs1_d), .rs2_d_i(rs2_d), .rs1_e_i(rs1_e), .rs2_e_i(rs2_e), .rd_e_i(rd_e),
    .rd_m_i(rd_m), .rd_w_i(rd_w), .reg_write_m_i(rwm), .reg_write_w_i(rww),
    .result_src_e_i(rsrc), .pc_src_e_i(pcs), .mdu_op_e_i(mdu_op), .mdu_done_i(mdu_done),
    .forward_a_e_o(s_fa), .forward_b_e_o(s_fb),
    .stall_f_o(s_stall_f), .stall_d_o(s_stall_d), .stall_e_o(s_stall_e),
    .flush_d_o(s_flush_d), .flush_e_o(s_flush_e), .flush_m_o(s_flush_m),
    .mdu_go_o(s_go), .mdu_busy_o(s_busy), .mdu_timeout_o(s_tmo), .stall_cycles_o(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  typedef struct {
    string      name;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       rwm, rww;
    logic [1:0] rsrc;
    logic       pcs;
    logic [1:0] fa, fb;
    logic       stall, fl_d, fl_e;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    rwm = 0; rww = 0; rsrc = 2'b00; pcs = 0; mdu_op = 0; mdu_done = 0;
  endtask

  task automatic sat_check(input string name);
    check(name, {29'd0, s_cnt}, (exp_cnt > 7) ? 32'd7 : exp_cnt);
  endtask

  initial begin
    vecs[0]  = '{"fwd_a_mem_over_wb", 0, 0, 5, 0, 0, 5, 5, 1, 1, 2'b00, 0, 2'b10, 2'b00, 0, 0, 0};
    vecs[1]  = '{"fwd_a_x0",          0, 0, 0, 0, 0, 5, 5, 1, 1, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0};
    vecs[2]  = '{"fwd_b_wb",          0, 0, 0, 9, 0, 9, 9, 0, 1, 2'b00, 0, 2'b00, 2'b01, 0, 0, 0};
    vecs[3]  = '{"fwd_a_wb_b_mem",    0, 0, 4, 3, 0, 3, 4, 1, 1, 2'b00, 0, 2'b01, 2'b10, 0, 0, 0};
    vecs[4]  = '{"fwd_no_write",      0, 0, 6, 6, 0, 6, 6, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0};
    vecs[5]  = '{"load_use_rs2",      1, 7, 0, 0, 7, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 1, 0, 1};
    vecs[6]  = '{"load_use_rs1",     12, 0, 0, 0,12, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 1, 0, 1};
    vecs[7]  = '{"load_rd_x0",        0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0, 0, 0};
    vecs[8]  = '{"non_load_match",    0, 7, 0, 0, 7, 0, 0, 0, 0, 2'b10, 0, 2'b00, 2'b00, 0, 0, 0};
    vecs[9]  = '{"branch_taken",      0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 0, 1, 1};
    vecs[10] = '{"load_no_match",     3, 4, 0, 0, 7, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0, 0, 0};

    // Reset state
    idle_inputs();
    rst = 1'b1;
    #12;
    check("rst_busy", busy, 0);
    check("rst_timeout", tmo, 0);
    check("rst_cnt", cnt, 0);
    check("rst_stall_f", stall_f, 0);
    check("rst_go", go, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_cnt", cnt, 0);

    // Vector table: one vector per cycle, IDLE state
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rs1_d = vecs[i].rs1_d; rs2_d = vecs[i].rs2_d; rs1_e = vecs[i].rs1_e;
      rs2_e = vecs[i].rs2_e; rd_e = vecs[i].rd_e; rd_m = vecs[i].rd_m; rd_w = vecs[i].rd_w;
      rwm = vecs[i].rwm; rww = vecs[i].rww; rsrc = vecs[i].rsrc; pcs = vecs[i].pcs;
      #1;
      check({vecs[i].name, "/fa"}, fa, vecs[i].fa);
      check({vecs[i].name, "/fb"}, fb, vecs[i].fb);
      check({vecs[i].name, "/stall_f"}, stall_f, vecs[i].stall);
      check({vecs[i].name, "/stall_d"}, stall_d, vecs[i].stall);
      check({vecs[i].name, "/stall_e"}, stall_e, 0);
      check({vecs[i].name, "/flush_d"}, flush_d, vecs[i].fl_d);
      check({vecs[i].name, "/flush_e"}, flush_e, vecs[i].fl_e);
      check({vecs[i].name, "/flush_m"}, flush_m, 0);
      check({vecs[i].name, "/go"}, go, 0);
      check({vecs[i].name, "/cnt"}, cnt, exp_cnt);
      if (vecs[i].stall) exp_cnt++;
    end
    @(negedge clk);
    idle_inputs();
    #1;
    check("table_cnt_total", cnt, 2);
    sat_check("sat_after_table");

    // MDU handshake: done on the 4th cycle after start
    go_seen = 0;
    mdu_op = 1;
    #1;
    go_seen += int'(go);
    check("mdu_start_stall_f", stall_f, 1);
    check("mdu_start_stall_e", stall_e, 1);
    check("mdu_start_flush_m", flush_m, 1);
    check("mdu_start_busy", busy, 0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 2) begin
        pcs = 1; rsrc = 2'b01; rd_e = 7; rs2_d = 7;
      end else begin
        pcs = 0; rsrc = 2'b00; rd_e = 0; rs2_d = 0;
      end
      #1;
      go_seen += int'(go);
      check("mdu_wait_busy", busy, 1);
      check("mdu_wait_stall_f", stall_f, 1);
      check("mdu_wait_stall_e", stall_e, 1);
      check("mdu_wait_flush_m", flush_m, 1);
      check("mdu_wait_flush_d", flush_d, 0);
      check("mdu_wait_flush_e", flush_e, 0);
    end
    @(negedge clk);
    mdu_done = 1;
    #1;
    go_seen += int'(go);
    check("mdu_done_stall_f", stall_f, 0);
    check("mdu_done_stall_e", stall_e, 0);
    check("mdu_done_flush_m", flush_m, 0);
    check("mdu_done_busy", busy, 1);
    @(negedge clk);
    idle_inputs();
    #1;
    go_seen += int'(go);
    exp_cnt += 4;
    check("mdu_back_idle", busy, 0);
    check("mdu_go_count", go_seen, 1);
    check("mdu_cnt", cnt, exp_cnt);
    check("mdu_no_timeout", tmo, 0);
    sat_check("sat_after_mdu");

    // Watchdog: done never arrives, release on the 8th wait cycle
    mdu_op = 1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      #1;
      check("wd_busy", busy, 1);
      check("wd_stall_f", stall_f, (c < 8) ? 1 : 0);
      check("wd_stall_e", stall_e, (c < 8) ? 1 : 0);
      check("wd_timeout_pending", tmo, 0);
    end
    @(negedge clk);
    mdu_op = 0;
    #1;
    exp_cnt += 8;
    check("wd_timeout_set", tmo, 1);
    check("wd_idle", busy, 0);
    check("wd_released", stall_f, 0);
    check("wd_cnt", cnt, exp_cnt);
    sat_check("sat_saturated");
    @(negedge clk);
    @(negedge clk);
    #1;
    check("wd_timeout_sticky", tmo, 1);
    check("sat_still", {29'd0, s_cnt}, 7);

    // Reset asserted in the 2nd MDU_WAIT cycle
    mdu_op = 1;
    @(negedge clk);
    #1;
    check("rmo_wait1_busy", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_cnt = 0;
    check("rmo_busy", busy, 0);
    check("rmo_cnt", cnt, 0);
    check("rmo_timeout_clr", tmo, 0);
    check("rmo_go", go, 0);
    check("rmo_stall_f", stall_f, 0);
    @(negedge clk);
    rst = 1'b0;
    mdu_op = 0;
    #1;
    check("rmo_after_stall_f", stall_f, 0);
    check("rmo_after_go", go, 0);
    check("rmo_after_busy", busy, 0);
    @(negedge clk);
    #1;
    check("rmo_after_cnt", cnt, 0);
    sat_check("rmo_sat_cnt");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
